// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the 8-bit datapath: accepts one instruction per
// handshake and expands it into registered, one-cycle write-enable pulse sequences.
`timescale 1ns/1ps
module control_sequencer #(
  parameter logic [1:0] FUNC_ADD = 2'b00,
  parameter logic [1:0] FUNC_AND = 2'b01,
  parameter logic [1:0] FUNC_OR  = 2'b10,
  parameter logic [1:0] FUNC_XOR = 2'b11,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [9:0]       instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             alu_so,
  input  logic             alu_uo,
  output logic             dp_reset,
  output logic [1:0]       reg_addr_we,
  output logic             reg_we,
  output logic             mar_we,
  output logic             mbr_out_we,
  output logic             mbr_in_we,
  output logic             mem_we,
  output logic             mbr_alu,
  output logic [1:0]       alu_func,
  output logic             alu_comp_b,
  output logic             alu_ci,
  output logic [1:0]       alu_reg_a,
  output logic [1:0]       alu_reg_b,
  output logic             done,
  output logic             so_flag,
  output logic             uo_flag,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_EXEC, S_WB, S_WB_END, S_MAR_SET, S_MAR_END, S_MEM_RD,
    S_MBR_END, S_MBR_SET, S_MBROUT_END, S_MEM_WR, S_MEM_END, S_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd8;

  state_t r_state;
  state_t w_next_state;

  logic [3:0] r_op;
  logic [1:0] r_rd, r_ra, r_rb;
  logic [3:0] w_op;
  logic [1:0] w_rd, w_ra, w_rb;
  logic       w_accept;
  logic       w_is_alu, w_is_load, w_is_store;

  logic             r_instr_ready, r_dp_reset;
  logic [1:0]       r_reg_addr_we;
  logic             r_reg_we, r_mar_we, r_mbr_out_we, r_mbr_in_we, r_mem_we, r_mbr_alu;
  logic [1:0]       r_alu_func;
  logic             r_alu_comp_b, r_alu_ci;
  logic [1:0]       r_alu_reg_a, r_alu_reg_b;
  logic             r_done, r_so, r_uo, r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic       w_nx_ready;
  logic [1:0] w_nx_reg_addr_we;
  logic       w_nx_reg_we, w_nx_mar_we, w_nx_mbr_out_we, w_nx_mbr_in_we, w_nx_mem_we, w_nx_mbr_alu;
  logic [1:0] w_nx_alu_func;
  logic       w_nx_comp_b, w_nx_ci;
  logic [1:0] w_nx_reg_a, w_nx_reg_b;
  logic       w_nx_done;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is registered and only high in IDLE,
  // so the source must hold instr stable until that edge.
  assign w_accept = instr_valid && r_instr_ready && (r_state == S_IDLE);

  always_comb begin
    w_op = r_op;
    w_rd = r_rd;
    w_ra = r_ra;
    w_rb = r_rb;
    if (w_accept) begin
      w_op = instr[9:6];
      w_rd = instr[5:4];
      w_ra = instr[3:2];
      w_rb = instr[1:0];
    end
  end

  assign w_is_alu   = (w_op >= OP_ADD) && (w_op <= OP_XOR);
  assign w_is_load  = (w_op == OP_LOAD);
  assign w_is_store = (w_op == OP_STORE);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_alu)                       w_next_state = S_EXEC;
          else if (w_is_load || w_is_store)   w_next_state = S_MAR_SET;
          else if (w_op == OP_HALT)           w_next_state = S_HALTED;
          else                                w_next_state = S_WB_END;
        end
      end
      S_EXEC:       w_next_state = S_WB;
      S_WB:         w_next_state = S_WB_END;
      S_WB_END:     w_next_state = S_IDLE;
      S_MAR_SET:    w_next_state = S_MAR_END;
      S_MAR_END:    w_next_state = (r_op == OP_LOAD) ? S_MEM_RD : S_MBR_SET;
      S_MEM_RD:     w_next_state = S_MBR_END;
      S_MBR_END:    w_next_state = S_WB;
      S_MBR_SET:    w_next_state = S_MBROUT_END;
      S_MBROUT_END: w_next_state = S_MEM_WR;
      S_MEM_WR:     w_next_state = S_MEM_END;
      S_MEM_END:    w_next_state = S_IDLE;
      S_HALTED:     w_next_state = S_HALTED;
      default:      w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered and then registered, so the
  // pins show the new state's controls in the same cycle the state is occupied.
  always_comb begin
    w_nx_ready       = 1'b0;
    w_nx_reg_addr_we = 2'd0;
    w_nx_reg_we      = 1'b0;
    w_nx_mar_we      = 1'b0;
    w_nx_mbr_out_we  = 1'b0;
    w_nx_mbr_in_we   = 1'b0;
    w_nx_mem_we      = 1'b0;
    w_nx_mbr_alu     = 1'b0;
    w_nx_alu_func    = FUNC_ADD;
    w_nx_comp_b      = 1'b0;
    w_nx_ci          = 1'b0;
    w_nx_reg_a       = 2'd0;
    w_nx_reg_b       = 2'd0;
    w_nx_done        = 1'b0;

    if ((w_next_state != S_IDLE) && (w_next_state != S_HALTED)) begin
      if (w_is_alu) begin
        w_nx_reg_a       = w_ra;
        w_nx_reg_b       = w_rb;
        w_nx_reg_addr_we = w_rd;
        w_nx_comp_b      = (w_op == OP_SUB);
        w_nx_ci          = (w_op == OP_SUB);
        case (w_op)
          OP_AND:  w_nx_alu_func = FUNC_AND;
          OP_OR:   w_nx_alu_func = FUNC_OR;
          OP_XOR:  w_nx_alu_func = FUNC_XOR;
          default: w_nx_alu_func = FUNC_ADD;
        endcase
      end else if (w_is_load) begin
        // OR of a register with itself passes the address through the ALU to MAR
        w_nx_reg_a    = w_ra;
        w_nx_reg_b    = w_ra;
        w_nx_alu_func = FUNC_OR;
        if ((w_next_state == S_MBR_END) || (w_next_state == S_WB) ||
            (w_next_state == S_WB_END)) begin
          w_nx_mbr_alu     = 1'b1;
          w_nx_reg_addr_we = w_rd;
        end
      end else if (w_is_store) begin
        w_nx_alu_func = FUNC_OR;
        if ((w_next_state == S_MAR_SET) || (w_next_state == S_MAR_END)) begin
          w_nx_reg_a = w_ra;
          w_nx_reg_b = w_ra;
        end else begin
          w_nx_reg_a = w_rb;
          w_nx_reg_b = w_rb;
        end
      end
    end

    case (w_next_state)
      S_IDLE:    w_nx_ready      = 1'b1;
      S_WB:      w_nx_reg_we     = 1'b1;
      S_MAR_SET: w_nx_mar_we     = 1'b1;
      S_MEM_RD:  w_nx_mbr_in_we  = 1'b1;
      S_MBR_SET: w_nx_mbr_out_we = 1'b1;
      S_MEM_WR:  w_nx_mem_we     = 1'b1;
      S_WB_END:  w_nx_done       = 1'b1;
      S_MEM_END: w_nx_done       = 1'b1;
      default:   w_nx_done       = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_rd    <= 2'd0;
      r_ra    <= 2'd0;
      r_rb    <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op <= instr[9:6];
        r_rd <= instr[5:4];
        r_ra <= instr[3:2];
        r_rb <= instr[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_ready <= 1'b0;
      r_dp_reset    <= 1'b1;
      r_reg_addr_we <= 2'd0;
      r_reg_we      <= 1'b0;
      r_mar_we      <= 1'b0;
      r_mbr_out_we  <= 1'b0;
      r_mbr_in_we   <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mbr_alu     <= 1'b0;
      r_alu_func    <= 2'd0;
      r_alu_comp_b  <= 1'b0;
      r_alu_ci      <= 1'b0;
      r_alu_reg_a   <= 2'd0;
      r_alu_reg_b   <= 2'd0;
      r_done        <= 1'b0;
    end else begin
      r_instr_ready <= w_nx_ready;
      r_dp_reset    <= 1'b0;
      r_reg_addr_we <= w_nx_reg_addr_we;
      r_reg_we      <= w_nx_reg_we;
      r_mar_we      <= w_nx_mar_we;
      r_mbr_out_we  <= w_nx_mbr_out_we;
      r_mbr_in_we   <= w_nx_mbr_in_we;
      r_mem_we      <= w_nx_mem_we;
      r_mbr_alu     <= w_nx_mbr_alu;
      r_alu_func    <= w_nx_alu_func;
      r_alu_comp_b  <= w_nx_comp_b;
      r_alu_ci      <= w_nx_ci;
      r_alu_reg_a   <= w_nx_reg_a;
      r_alu_reg_b   <= w_nx_reg_b;
      r_done        <= w_nx_done;
    end
  end

  // Status: overflow flags follow only arithmetic ops, illegal is sticky until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_so      <= 1'b0;
      r_uo      <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if ((r_state == S_WB_END) && ((r_op == OP_ADD) || (r_op == OP_SUB))) begin
        r_so <= alu_so;
        r_uo <= alu_uo;
      end
      if (w_accept && (instr[9:6] > OP_HALT)) begin
        r_illegal <= 1'b1;
      end
      if (w_nx_done) begin
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign instr_ready = r_instr_ready;
  assign dp_reset    = r_dp_reset;
  assign reg_addr_we = r_reg_addr_we;
  assign reg_we      = r_reg_we;
  assign mar_we      = r_mar_we;
  assign mbr_out_we  = r_mbr_out_we;
  assign mbr_in_we   = r_mbr_in_we;
  assign mem_we      = r_mem_we;
  assign mbr_alu     = r_mbr_alu;
  assign alu_func    = r_alu_func;
  assign alu_comp_b  = r_alu_comp_b;
  assign alu_ci      = r_alu_ci;
  assign alu_reg_a   = r_alu_reg_a;
  assign alu_reg_b   = r_alu_reg_b;
  assign done        = r_done;
  assign so_flag     = r_so;
  assign uo_flag     = r_uo;
  assign illegal     = r_illegal;
  assign retired     = r_retired;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-instruction expected-cycle plan model
// checked every cycle, plus hand-computed spot checks.
`timescale 1ns/1ps
module tb_control_sequencer;

  logic        clk;
  logic        reset_n = 1'b0;
  logic [9:0]  instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        alu_so = 1'b0;
  logic        alu_uo = 1'b0;
  logic        dp_reset;
  logic [1:0]  reg_addr_we;
  logic        reg_we, mar_we, mbr_out_we, mbr_in_we, mem_we, mbr_alu;
  logic [1:0]  alu_func;
  logic        alu_comp_b, alu_ci;
  logic [1:0]  alu_reg_a, alu_reg_b;
  logic        done, so_flag, uo_flag, illegal;
  logic [15:0] retired;
  logic [3:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_so(alu_so), .alu_uo(alu_uo), .dp_reset(dp_reset),
    .reg_addr_we(reg_addr_we), .reg_we(reg_we), .mar_we(mar_we), .mbr_out_we(mbr_out_we),
    .mbr_in_we(mbr_in_we), .mem_we(mem_we), .mbr_alu(mbr_alu), .alu_func(alu_func),
    .alu_comp_b(alu_comp_b), .alu_ci(alu_ci), .alu_reg_a(alu_reg_a), .alu_reg_b(alu_reg_b),
    .done(done), .so_flag(so_flag), .uo_flag(uo_flag), .illegal(illegal),
    .retired(retired), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model: expected output record for each cycle ----------------
  typedef struct packed {
    logic       ready;
    logic [1:0] rae;
    logic       rwe, mar, mbo, mbi, mem, mbra;
    logic [1:0] func;
    logic       comp, ci;
    logic [1:0] ra, rb;
    logic       done;
    logic       flag_ld;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        m_cur = '0;
  bit          m_started = 0;
  bit          m_halted = 0;
  logic        m_so = 0, m_uo = 0, m_ill = 0;
  logic [15:0] m_ret = '0;

  task automatic plan_instr(input logic [9:0] ins);
    logic [3:0] op;
    logic [1:0] rd, ra, rb;
    rec_t b;
    op = ins[9:6]; rd = ins[5:4]; ra = ins[3:2]; rb = ins[1:0];
    b = '0;
    if (op >= 4'd1 && op <= 4'd5) begin
      b.ra = ra; b.rb = rb; b.rae = rd;
      case (op)
        4'd3:    b.func = 2'b01;
        4'd4:    b.func = 2'b10;
        4'd5:    b.func = 2'b11;
        default: b.func = 2'b00;
      endcase
      b.comp = (op == 4'd2);
      b.ci   = (op == 4'd2);
      exp_q.push_back(b);
      b.rwe = 1; exp_q.push_back(b); b.rwe = 0;
      b.done = 1; b.flag_ld = (op <= 4'd2); exp_q.push_back(b);
    end else if (op == 4'd6) begin
      b.ra = ra; b.rb = ra; b.func = 2'b10;
      b.mar = 1; exp_q.push_back(b); b.mar = 0;
      exp_q.push_back(b);
      b.mbi = 1; exp_q.push_back(b); b.mbi = 0;
      b.mbra = 1; b.rae = rd;
      exp_q.push_back(b);
      b.rwe = 1; exp_q.push_back(b); b.rwe = 0;
      b.done = 1; exp_q.push_back(b);
    end else if (op == 4'd7) begin
      b.ra = ra; b.rb = ra; b.func = 2'b10;
      b.mar = 1; exp_q.push_back(b); b.mar = 0;
      exp_q.push_back(b);
      b.ra = rb; b.rb = rb;
      b.mbo = 1; exp_q.push_back(b); b.mbo = 0;
      exp_q.push_back(b);
      b.mem = 1; exp_q.push_back(b); b.mem = 0;
      b.done = 1; exp_q.push_back(b);
    end else if (op == 4'd8) begin
      m_halted = 1;
    end else begin
      if (op >= 4'd9) m_ill = 1;
      b.done = 1; exp_q.push_back(b);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        m_cur = '0; m_started = 0; m_halted = 0;
        m_so = 0; m_uo = 0; m_ill = 0; m_ret = '0;
      end else begin
        if (m_cur.flag_ld) begin
          m_so = alu_so;
          m_uo = alu_uo;
        end
        if (m_cur.ready && instr_valid) plan_instr(instr);
        m_started = 1;
        if (exp_q.size() > 0) begin
          m_cur = exp_q.pop_front();
        end else begin
          m_cur = '0;
          m_cur.ready = !m_halted;
        end
        if (m_cur.done) m_ret = m_ret + 16'd1;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  initial begin
    logic [37:0] act, expv;
    forever begin
      @(negedge clk);
      act  = {instr_ready, dp_reset, reg_addr_we, reg_we, mar_we, mbr_out_we, mbr_in_we,
              mem_we, mbr_alu, alu_func, alu_comp_b, alu_ci, alu_reg_a, alu_reg_b, done,
              so_flag, uo_flag, illegal, retired};
      expv = {m_cur.ready, !m_started, m_cur.rae, m_cur.rwe, m_cur.mar, m_cur.mbo, m_cur.mbi,
              m_cur.mem, m_cur.mbra, m_cur.func, m_cur.comp, m_cur.ci, m_cur.ra, m_cur.rb,
              m_cur.done, m_so, m_uo, m_ill, m_ret};
      n_cmp++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t state=%0d actual=%h required=%h", $time, dbg_state, act, expv);
      end
    end
  end

  // ---------------- driver / spot-check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, expv);
    end
  endtask

  // Entered at a falling edge; returns 1ns after the accepting rising edge.
  task automatic send(input logic [9:0] ins, input bit hold, output int waited);
    instr = ins;
    instr_valid = 1'b1;
    waited = 0;
    forever begin
      if (instr_ready === 1'b1) begin
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
        return;
      end
      waited++;
      if (waited > 40) begin
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout t=%0t actual=no_accept required=accept", $time);
        instr_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int w;
    int ready_seen, done_seen;

    repeat (3) @(negedge clk);
    check("rst_dp_reset", dp_reset, 1);
    check("rst_ready", instr_ready, 0);
    check("rst_retired", retired, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_dp_reset", dp_reset, 0);
    check("post_rst_ready", instr_ready, 1);

    // ADD r2 = r0 + r1
    send(10'h061, 0, w);
    @(negedge clk);
    check("add_ready_low", instr_ready, 0);
    check("add_reg_a", alu_reg_a, 0);
    check("add_reg_b", alu_reg_b, 1);
    check("add_func", alu_func, 0);
    check("add_comp_ci", {alu_comp_b, alu_ci}, 0);
    check("add_rd", reg_addr_we, 2);
    check("add_exec_we", reg_we, 0);
    @(negedge clk);
    check("add_wb_we", reg_we, 1);
    @(negedge clk);
    check("add_end_we", reg_we, 0);
    check("add_done", done, 1);
    check("add_retired", retired, 1);
    @(negedge clk);
    check("add_back_idle", instr_ready, 1);

    // SUB r3 = r1 - r2 with signed overflow reported
    alu_so = 1'b1; alu_uo = 1'b0;
    send(10'h0B6, 0, w);
    @(negedge clk);
    check("sub_comp_ci", {alu_comp_b, alu_ci}, 2'b11);
    check("sub_rd", reg_addr_we, 3);
    check("sub_regs", {alu_reg_a, alu_reg_b}, 4'b0110);
    repeat (3) @(negedge clk);
    check("sub_so_flag", so_flag, 1);
    check("sub_uo_flag", uo_flag, 0);
    alu_so = 1'b0;

    // reset in the middle of a write-back pulse
    send(10'h061, 0, w);
    @(negedge clk);
    @(posedge clk);
    #1 check("mid_wb_we_high", reg_we, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_reg_we", reg_we, 0);
    check("mid_rst_dp_reset", dp_reset, 1);
    check("mid_rst_retired", retired, 0);
    check("mid_rst_so", so_flag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_dp_reset", dp_reset, 0);
    check("rel_ready", instr_ready, 1);

    // LOAD r1 = mem[r2], then STORE mem[r0] = r3 with valid held throughout
    send(10'h198, 1, w);
    send(10'h1C3, 0, w);
    check("load_accept_gap", w, 7);
    @(negedge clk);
    check("st_mar_we", mar_we, 1);
    check("st_mar_reg_a", alu_reg_a, 0);
    @(negedge clk);
    @(negedge clk);
    check("st_mbr_out_we", mbr_out_we, 1);
    check("st_mbr_reg_a", alu_reg_a, 3);
    @(negedge clk);
    @(negedge clk);
    check("st_mem_we", mem_we, 1);
    @(negedge clk);
    check("st_done", done, 1);
    check("st_retired", retired, 2);
    @(negedge clk);

    // illegal opcode 15
    send(10'h3C0, 0, w);
    @(negedge clk);
    check("ill_flag", illegal, 1);
    check("ill_done", done, 1);
    check("ill_no_we", {reg_we, mar_we, mbr_out_we, mbr_in_we, mem_we}, 0);
    check("ill_retired", retired, 3);
    @(negedge clk);
    send(10'h061, 0, w);
    repeat (3) @(negedge clk);
    check("ill_sticky", illegal, 1);
    check("ill_then_add_retired", retired, 4);
    @(negedge clk);

    // HALT, then a held request that must never be taken
    send(10'h200, 0, w);
    instr = 10'h061;
    instr_valid = 1'b1;
    ready_seen = 0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (instr_ready) ready_seen++;
      if (done) done_seen++;
    end
    check("halt_ready_seen", ready_seen, 0);
    check("halt_done_seen", done_seen, 0);
    check("halt_retired", retired, 4);
    instr_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
